// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the write-request type for the register-file write arbiter.
// The optional WB_BYPASS_EN build macro is consumed by regfile_write_arbiter.sv.
package regfile_write_arbiter_pkg;

  localparam int REG_WIDTH          = 32;
  localparam int ADDRESS_PORT_WIDTH = 5;
  localparam int REG_COUNT          = 32;
  localparam int WB_FIFO_DEPTH      = 2;
  localparam int WB_REQ_BITS        = ADDRESS_PORT_WIDTH + REG_WIDTH;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // x0 is hardwired, so anything addressed to it is swallowed
  function automatic logic isNonZeroReg(input logic [ADDRESS_PORT_WIDTH-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO of wb_req_t entries that parks long-latency results while the
// register-file port is taken. Full/empty come from a registered occupancy count.
module regfile_write_arbiter_wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WB_REQ_BITS-1:0] pushData_i,
  input  logic                   pop_i,
  output logic [WB_REQ_BITS-1:0] head_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = doPop ? nextPtr(rdPtr_q) : rdPtr_q;
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid
  always_ff @(posedge clock_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wb_req_t'(pushData_i);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole writer of the register file: merges WB-stage and long-latency results, tracks
// busy registers for issued LL ops and raises the ID stall. WB_BYPASS_EN adds forwarding.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          wb_valid,
  input  logic [ADDRESS_PORT_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]          wb_data,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [ADDRESS_PORT_WIDTH-1:0] ll_rd,
  input  logic [REG_WIDTH-1:0]          ll_data,
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic [ADDRESS_PORT_WIDTH-1:0] iss_rd,
  input  logic [ADDRESS_PORT_WIDTH-1:0] rs1,
  input  logic [ADDRESS_PORT_WIDTH-1:0] rs2,
  output logic                          stall,
  output logic                          byp_hit1,
  output logic                          byp_hit2,
  output logic [REG_WIDTH-1:0]          byp_data1,
  output logic [REG_WIDTH-1:0]          byp_data2,
  output logic                          RegWrite,
  output logic [ADDRESS_PORT_WIDTH-1:0] WriteAddress,
  output logic [REG_WIDTH-1:0]          WriteData
);

  logic                          llAccept;
  logic                          issAccept;
  logic                          fifoPush;
  logic                          fifoPop;
  logic                          fifoEmpty;
  logic                          fifoFull;
  logic [WB_REQ_BITS-1:0]        fifoHead;
  wb_req_t                       llReq;
  wb_req_t                       selReq;
  logic                          selValid;
  logic                          selFromLl;
  logic                          regWrite_q, regWrite_d;
  logic [ADDRESS_PORT_WIDTH-1:0] writeAddr_q, writeAddr_d;
  logic [REG_WIDTH-1:0]          writeData_q, writeData_d;
  logic                          fromLl_q, fromLl_d;
  logic [REG_COUNT-1:0]          busy_q, busy_d;
  logic                          rs1Busy, rs2Busy;
  logic                          rs1Pend, rs2Pend;

  assign llReq     = '{rd: ll_rd, data: ll_data};
  assign ll_ready  = !fifoFull;
  assign llAccept  = ll_valid && !fifoFull;
  assign iss_ready = !isNonZeroReg(iss_rd) || !busy_q[iss_rd];
  assign issAccept = iss_valid && iss_ready && isNonZeroReg(iss_rd);

  regfile_write_arbiter_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) llFifo (
    .clock_i   (CLK),
    .reset_i   (Reset),
    .push_i    (fifoPush),
    .pushData_i(llReq),
    .pop_i     (fifoPop),
    .head_o    (fifoHead),
    .empty_o   (fifoEmpty),
    .full_o    (fifoFull)
  );

  // WB always wins; buffered LL results drain before a fresh LL result may pass straight through
  always_comb begin
    selValid  = 1'b0;
    selFromLl = 1'b0;
    selReq    = '0;
    fifoPop   = 1'b0;
    fifoPush  = 1'b0;
    if (wb_valid) begin
      selValid = 1'b1;
      selReq   = '{rd: wb_rd, data: wb_data};
      fifoPush = llAccept;
    end else if (!fifoEmpty) begin
      selValid  = 1'b1;
      selFromLl = 1'b1;
      selReq    = wb_req_t'(fifoHead);
      fifoPop   = 1'b1;
      fifoPush  = llAccept;
    end else if (llAccept) begin
      selValid  = 1'b1;
      selFromLl = 1'b1;
      selReq    = llReq;
    end
  end

  always_comb begin
    regWrite_d  = selValid && isNonZeroReg(selReq.rd);
    writeAddr_d = regWrite_d ? selReq.rd : '0;
    writeData_d = regWrite_d ? selReq.data : '0;
    fromLl_d    = regWrite_d && selFromLl;
  end

  // A register stays busy until the cycle its LL result is actually committed has ended
  always_comb begin
    busy_d = busy_q;
    if (regWrite_q && fromLl_q) begin
      busy_d[writeAddr_q] = 1'b0;
    end
    if (issAccept) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      regWrite_q  <= 1'b0;
      writeAddr_q <= '0;
      writeData_q <= '0;
      fromLl_q    <= 1'b0;
      busy_q      <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      writeAddr_q <= writeAddr_d;
      writeData_q <= writeData_d;
      fromLl_q    <= fromLl_d;
      busy_q      <= busy_d;
    end
  end

  assign RegWrite     = regWrite_q;
  assign WriteAddress = writeAddr_q;
  assign WriteData    = writeData_q;

  assign rs1Busy = isNonZeroReg(rs1) && busy_q[rs1];
  assign rs2Busy = isNonZeroReg(rs2) && busy_q[rs2];
  assign rs1Pend = regWrite_q && (writeAddr_q == rs1) && isNonZeroReg(rs1);
  assign rs2Pend = regWrite_q && (writeAddr_q == rs2) && isNonZeroReg(rs2);

`ifdef WB_BYPASS_EN
  // The in-flight write is forwarded, so only outstanding LL ops hold ID
  assign byp_hit1  = rs1Pend;
  assign byp_hit2  = rs2Pend;
  assign byp_data1 = writeData_q;
  assign byp_data2 = writeData_q;
  assign stall     = rs1Busy || rs2Busy;
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
  assign stall     = rs1Busy || rs2Busy || rs1Pend || rs2Pend;
`endif

  wbToBusyReg: assert property (@(posedge CLK) disable iff (Reset)
    !(wb_valid && isNonZeroReg(wb_rd) && busy_q[wb_rd]));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios then random traffic,
// checked against a queue-based reference model. Works with or without WB_BYPASS_EN.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        wb_valid, ll_valid, iss_valid;
  logic [4:0]  wb_rd, ll_rd, iss_rd, rs1, rs2;
  logic [31:0] wb_data, ll_data;
  logic        ll_ready, iss_ready, stall, byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
  logic        RegWrite;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  wb_req_t     llBuf[$];
  logic [31:0] busyM;
  logic        pendValid, pendFromLl;
  logic [4:0]  pendRd;
  logic [31:0] pendData;
  int          cycleCnt = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    testsRun++;
    if (act !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, want, cycleCnt);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check combinational outputs, advance the model
  task automatic applyStimulus(
    input  logic rst,
    input  logic wbV, input logic [4:0] wbRd, input logic [31:0] wbData,
    input  logic llV, input logic [4:0] llRd, input logic [31:0] llData,
    input  logic issV, input logic [4:0] issRd,
    input  logic [4:0] r1, input logic [4:0] r2,
    output logic llAcc, output logic issAcc);
    logic    expLlReady, expIssReady, hit1, hit2, expStall, hasC, cFromLl;
    wb_req_t c;
    @(negedge CLK);
    Reset = rst; wb_valid = wbV; wb_rd = wbRd; wb_data = wbData;
    ll_valid = llV; ll_rd = llRd; ll_data = llData;
    iss_valid = issV; iss_rd = issRd; rs1 = r1; rs2 = r2;
    #1;
    expLlReady  = llBuf.size() < WB_FIFO_DEPTH;
    expIssReady = (issRd == 5'd0) || !busyM[issRd];
    hit1 = pendValid && (pendRd == r1) && (r1 != 5'd0);
    hit2 = pendValid && (pendRd == r2) && (r2 != 5'd0);
    expStall = ((r1 != 5'd0) && busyM[r1]) || ((r2 != 5'd0) && busyM[r2]);
`ifdef WB_BYPASS_EN
    checkOutput("byp_hit1", 32'(byp_hit1), 32'(hit1));
    checkOutput("byp_hit2", 32'(byp_hit2), 32'(hit2));
    if (hit1) checkOutput("byp_data1", byp_data1, pendData);
    if (hit2) checkOutput("byp_data2", byp_data2, pendData);
`else
    expStall = expStall || hit1 || hit2;
    checkOutput("byp_hit", {30'd0, byp_hit1, byp_hit2}, 32'd0);
    checkOutput("byp_data", byp_data1 | byp_data2, 32'd0);
`endif
    checkOutput("ll_ready", 32'(ll_ready), 32'(expLlReady));
    checkOutput("iss_ready", 32'(iss_ready), 32'(expIssReady));
    checkOutput("stall", 32'(stall), 32'(expStall));
    llAcc  = llV && expLlReady && !rst;
    issAcc = issV && expIssReady && !rst;
    if (rst) begin
      llBuf.delete();
      busyM     = '0;
      pendValid = 1'b0;
      pendFromLl = 1'b0;
    end else begin
      if (pendValid && pendFromLl) busyM[pendRd] = 1'b0;
      if (issAcc && issRd != 5'd0) busyM[issRd] = 1'b1;
      // Accepted LL results join the buffer; a pass-through is simply an immediate pop
      if (llAcc) llBuf.push_back('{rd: llRd, data: llData});
      hasC = 1'b0; cFromLl = 1'b0; c = '0;
      if (wbV) begin
        c = '{rd: wbRd, data: wbData}; hasC = 1'b1;
      end else if (llBuf.size() > 0) begin
        c = llBuf.pop_front(); hasC = 1'b1; cFromLl = 1'b1;
      end
      pendValid  = hasC && (c.rd != 5'd0);
      pendRd     = c.rd;
      pendData   = c.data;
      pendFromLl = cFromLl;
      if (pendValid) expQ.push_back('{rd: c.rd, data: c.data, due: cycleCnt + 1});
    end
  endtask

  task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
    logic a, b;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2, a, b);
  endtask

  // Monitor: every register-file write must match the oldest expected write, on time
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0 && expQ[0].due == cycleCnt) begin
        e = expQ.pop_front();
        checkOutput("regWrite", 32'(RegWrite), 32'd1);
        checkOutput("writeAddress", 32'(WriteAddress), 32'(e.rd));
        checkOutput("writeData", WriteData, e.data);
      end else begin
        checkOutput("regWriteIdle", 32'(RegWrite), 32'd0);
      end
    end
  end

  initial begin
    logic        llAcc, issAcc, llHeld, rst, wbV, issV;
    logic [4:0]  hRd, wbRd, issRd;
    logic [31:0] hData;
    logic [4:0]  outstanding[$];
    int          idx;

    Reset = 1'b1; wb_valid = 1'b0; ll_valid = 1'b0; iss_valid = 1'b0;
    wb_rd = '0; ll_rd = '0; iss_rd = '0; rs1 = '0; rs2 = '0; wb_data = '0; ll_data = '0;
    busyM = '0; pendValid = 1'b0; pendFromLl = 1'b0; pendRd = '0; pendData = '0;

    // Reset held two cycles, then all outputs must read zero
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, llAcc, issAcc);
    idleCycle(5'd0, 5'd0);
    checkOutput("resetOutputs", {31'd0, RegWrite} | 32'(WriteAddress) | WriteData, 32'd0);

    // Plain WB write
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, llAcc, issAcc);
    idleCycle(5'd0, 5'd0);

    // Issue to x7, read it while busy, then complete it
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, llAcc, issAcc);
    idleCycle(5'd7, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd7, 5'd0, llAcc, issAcc);
    idleCycle(5'd7, 5'd0);
    idleCycle(5'd7, 5'd0);
    idleCycle(5'd7, 5'd0);

    // WB contention for three cycles while LL results 8, 9, 10 arrive
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), 5'd0, 5'd0, llAcc, issAcc);
    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      applyStimulus(1'b0, cyc < 3, 5'(1 + cyc), 32'hA000 + 32'(cyc),
                    idx < 3, 5'(8 + idx), 32'h100 + 32'(idx), 1'b0, 5'd0, 5'd9, 5'd10, llAcc, issAcc);
      if (llAcc) idx++;
    end
    checkOutput("llDirectedAccepted", 32'(idx), 32'd3);

    // Everything aimed at x0 is swallowed
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 5'd0, 5'd0, llAcc, issAcc);
    idleCycle(5'd0, 5'd0);
    idleCycle(5'd0, 5'd0);

    // Read-after-write on the in-flight WB result
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, llAcc, issAcc);
    idleCycle(5'd3, 5'd3);
    idleCycle(5'd3, 5'd0);

    // Random traffic with one reset in the middle
    llHeld = 1'b0; hRd = '0; hData = '0;
    for (int i = 0; i < 3000; i++) begin
      rst  = (i == 1500);
      wbV  = ($urandom_range(0, 2) == 0);
      wbRd = 5'($urandom_range(0, 15));
      if (busyM[wbRd]) wbV = 1'b0;
      if (!llHeld && outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        llHeld = 1'b1;
        hRd    = outstanding.pop_front();
        hData  = $urandom;
      end
      issV  = ($urandom_range(0, 2) == 0);
      issRd = 5'($urandom_range(0, 15));
      applyStimulus(rst, wbV, wbRd, $urandom, llHeld, hRd, hData, issV, issRd,
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), llAcc, issAcc);
      if (llAcc) llHeld = 1'b0;
      if (issAcc) outstanding.push_back(issRd);
      if (rst) begin
        outstanding.delete();
        llHeld = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) idleCycle(5'd0, 5'd0);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
